// File: rtl/bram_arb_pkg.sv
// Shared helpers for the BRAM port arbiter: id width, load latency
// and flattened-bus slice arithmetic.
package bram_arb_pkg;

    localparam int LOAD_LATENCY = 1;
    localparam int MAX_REQ      = 8;

    // Requester-id width, never narrower than one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Low bit of slice i in a bus of w-bit fields.
    function automatic int slice_lo(input int i, input int w);
        return i * w;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts after the last winner.
// Ports: req/en in, grant/grant_id out; owns the priority pointer.
module rr_arbiter #(
    parameter int N   = 2,
    parameter int IDW = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic           en,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] grant_id
);

    logic [IDW-1:0] ptr;
    logic [IDW-1:0] idx;
    logic           found;

    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        idx      = '0;
        for (int k = 1; k <= N; k++) begin
            idx = IDW'((int'(ptr) + k) % N);
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_id   = idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= IDW'(N - 1);
        end else if (en && found) begin
            ptr <= grant_id;
        end
    end

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one dual-port BRAM among NUM_REQ kernels: port 0 loads, port 1
// stores, each with its own round-robin arbiter and per-requester
// response slots. Ports: ld_req_*/ld_rsp_* load channels, st_* store
// channels, ce/we/address/dout/din BRAM ports; rst is async active-low.
// Optional BRAM_ARB_FWD_EN: same-cycle store data forwarded to a load of
// the same address (write-before-read); default returns read-first din0.
module bram_port_arbiter
    import bram_arb_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            ld_req_valid,
    output logic [NUM_REQ-1:0]            ld_req_ready,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] ld_req_addr,
    output logic [NUM_REQ-1:0]            ld_rsp_valid,
    input  logic [NUM_REQ-1:0]            ld_rsp_ready,
    output logic [NUM_REQ*DATA_WIDTH-1:0] ld_rsp_data,
    input  logic [NUM_REQ-1:0]            st_valid,
    output logic [NUM_REQ-1:0]            st_ready,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] st_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] st_data,
    output logic                          ce0,
    output logic                          we0,
    output logic [ADDR_WIDTH-1:0]         address0,
    output logic [DATA_WIDTH-1:0]         dout0,
    input  logic [DATA_WIDTH-1:0]         din0,
    output logic                          ce1,
    output logic                          we1,
    output logic [ADDR_WIDTH-1:0]         address1,
    output logic [DATA_WIDTH-1:0]         dout1,
    input  logic [DATA_WIDTH-1:0]         din1
);

    localparam int IDW = id_width(NUM_REQ);

    logic [NUM_REQ-1:0]            ld_pop;
    logic [NUM_REQ-1:0]            ld_elig;
    logic [NUM_REQ-1:0]            ld_gnt;
    logic [IDW-1:0]                ld_id;
    logic                          ld_any;
    logic [ADDR_WIDTH-1:0]         ld_addr_sel;

    logic [NUM_REQ-1:0]            st_elig;
    logic [NUM_REQ-1:0]            st_gnt;
    logic [IDW-1:0]                st_id;
    logic                          st_any;
    logic [ADDR_WIDTH-1:0]         st_addr_sel;
    logic [DATA_WIDTH-1:0]         st_data_sel;

    logic                          inflight;
    logic [IDW-1:0]                inflight_id;
    logic [NUM_REQ-1:0]            rsp_v;
    logic [NUM_REQ*DATA_WIDTH-1:0] slot;
    logic [ADDR_WIDTH-1:0]         addr0_q;
    logic [ADDR_WIDTH-1:0]         addr1_q;
    logic [DATA_WIDTH-1:0]         dout1_q;
    logic [DATA_WIDTH-1:0]         cap_data;

    logic                          unused;
    assign unused = ^din1;

    // A slot being drained this cycle can accept the next response, so
    // the consumer's handshake counts as free space. Grants are held off
    // while reset is asserted so every output reads 0.
    assign ld_pop  = rsp_v & ld_rsp_ready;
    assign ld_elig = ld_req_valid & (~rsp_v | ld_rsp_ready) & {NUM_REQ{rst}};
    assign st_elig = st_valid & {NUM_REQ{rst}};

    rr_arbiter #(.N(NUM_REQ), .IDW(IDW)) u_ld_arb (
        .clk      (clk),
        .rst      (rst),
        .req      (ld_elig),
        .en       (1'b1),
        .grant    (ld_gnt),
        .grant_id (ld_id)
    );

    rr_arbiter #(.N(NUM_REQ), .IDW(IDW)) u_st_arb (
        .clk      (clk),
        .rst      (rst),
        .req      (st_elig),
        .en       (1'b1),
        .grant    (st_gnt),
        .grant_id (st_id)
    );

    assign ld_any      = |ld_gnt;
    assign st_any      = |st_gnt;
    assign ld_addr_sel = ld_req_addr[slice_lo(int'(ld_id), ADDR_WIDTH) +: ADDR_WIDTH];
    assign st_addr_sel = st_addr[slice_lo(int'(st_id), ADDR_WIDTH) +: ADDR_WIDTH];
    assign st_data_sel = st_data[slice_lo(int'(st_id), DATA_WIDTH) +: DATA_WIDTH];

    assign ld_req_ready = ld_gnt;
    assign st_ready     = st_gnt;

    // Idle ports keep presenting the last granted address/data.
    assign ce0      = ld_any;
    assign we0      = 1'b0;
    assign address0 = ld_any ? ld_addr_sel : addr0_q;
    assign dout0    = '0;
    assign ce1      = st_any;
    assign we1      = st_any;
    assign address1 = st_any ? st_addr_sel : addr1_q;
    assign dout1    = st_any ? st_data_sel : dout1_q;

    assign ld_rsp_valid = rsp_v;
    assign ld_rsp_data  = slot;

`ifdef BRAM_ARB_FWD_EN
    logic                  fwd_hit;
    logic [DATA_WIDTH-1:0] fwd_data;

    // The BRAM reads first, so a same-cycle store to the load address
    // would be missed; remember it and substitute at capture time.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fwd_hit  <= 1'b0;
            fwd_data <= '0;
        end else begin
            fwd_hit  <= ld_any && st_any && (ld_addr_sel == st_addr_sel);
            fwd_data <= st_data_sel;
        end
    end

    assign cap_data = fwd_hit ? fwd_data : din0;
`else
    assign cap_data = din0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight    <= 1'b0;
            inflight_id <= '0;
            rsp_v       <= '0;
            slot        <= '0;
            addr0_q     <= '0;
            addr1_q     <= '0;
            dout1_q     <= '0;
        end else begin
            inflight <= ld_any;
            if (ld_any) begin
                inflight_id <= ld_id;
                addr0_q     <= ld_addr_sel;
            end
            if (st_any) begin
                addr1_q <= st_addr_sel;
                dout1_q <= st_data_sel;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (inflight && int'(inflight_id) == i) begin
                    rsp_v[i] <= 1'b1;
                    slot[slice_lo(i, DATA_WIDTH) +: DATA_WIDTH] <= cap_data;
                end else if (ld_pop[i]) begin
                    rsp_v[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter with a read-first BRAM model.
// Inputs change 1ns after posedge; outputs are checked on negedge.
module tb_bram_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  ld_req_valid;
    logic [1:0]  ld_req_ready;
    logic [63:0] ld_req_addr;
    logic [1:0]  ld_rsp_valid;
    logic [1:0]  ld_rsp_ready;
    logic [63:0] ld_rsp_data;
    logic [1:0]  st_valid;
    logic [1:0]  st_ready;
    logic [63:0] st_addr;
    logic [63:0] st_data;
    logic        ce0, we0, ce1, we1;
    logic [31:0] address0, address1, dout0, dout1, din0, din1;

    logic [31:0] mem [256];
    int checks = 0;
    int errors = 0;
    logic [31:0] fwd_exp;

    always #5 clk = ~clk;

    bram_port_arbiter dut (
        .clk(clk), .rst(rst),
        .ld_req_valid(ld_req_valid), .ld_req_ready(ld_req_ready),
        .ld_req_addr(ld_req_addr), .ld_rsp_valid(ld_rsp_valid),
        .ld_rsp_ready(ld_rsp_ready), .ld_rsp_data(ld_rsp_data),
        .st_valid(st_valid), .st_ready(st_ready),
        .st_addr(st_addr), .st_data(st_data),
        .ce0(ce0), .we0(we0), .address0(address0), .dout0(dout0),
        .din0(din0), .ce1(ce1), .we1(we1), .address1(address1),
        .dout1(dout1), .din1(din1)
    );

    // Read-first BRAM; preload happens while reset is held.
    always @(posedge clk) begin
        if (!rst) begin
            mem[3]  <= 32'h0;
            mem[5]  <= 32'hA5A5;
            mem[9]  <= 32'h9999;
            mem[20] <= 32'h20;
            mem[21] <= 32'h21;
        end
        if (ce0) din0 <= mem[address0[7:0]];
        if (ce1 && we1) mem[address1[7:0]] <= dout1;
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
`ifdef BRAM_ARB_FWD_EN
        fwd_exp = 32'hBEEF;
`else
        fwd_exp = 32'h0;
`endif
        din1 = 32'h0;
        rst = 1'b0;
        ld_req_valid = 2'b11;
        ld_req_addr = '0;
        ld_rsp_ready = 2'b11;
        st_valid = 2'b11;
        st_addr = '0;
        st_data = '0;
        repeat (3) nxt();
        smp();
        chk("rst_ld_ready", ld_req_ready, 2'b00);
        chk("rst_st_ready", st_ready, 2'b00);
        chk("rst_ce0", ce0, 1'b0);
        chk("rst_ce1", ce1, 1'b0);
        chk("rst_we1", we1, 1'b0);
        chk("rst_rsp_valid", ld_rsp_valid, 2'b00);
        chk("rst_address0", address0, 32'h0);

        nxt();
        rst = 1'b1;
        ld_req_valid = 2'b00;
        st_valid = 2'b00;
        nxt();

        // Single load of addr 5 by requester 0.
        nxt();
        ld_req_valid = 2'b01;
        ld_req_addr = {32'd0, 32'd5};
        smp();
        chk("single_ready", ld_req_ready, 2'b01);
        chk("single_ce0", ce0, 1'b1);
        chk("single_addr0", address0, 32'd5);
        chk("single_we0", we0, 1'b0);
        nxt();
        ld_req_valid = 2'b00;
        smp();
        chk("single_lat1_valid", ld_rsp_valid, 2'b00);
        chk("single_idle_ce0", ce0, 1'b0);
        chk("single_hold_addr0", address0, 32'd5);
        nxt();
        smp();
        chk("single_rsp_valid", ld_rsp_valid, 2'b01);
        chk("single_rsp_data", ld_rsp_data[31:0], 32'hA5A5);

        // Contention: pointer sits at 0, so requester 1 leads.
        ld_req_addr = {32'd21, 32'd20};
        for (int k = 0; k < 9; k++) begin
            nxt();
            ld_req_valid = (k < 6) ? 2'b11 : 2'b00;
            smp();
            chk($sformatf("cont_ready_%0d", k), ld_req_ready,
                (k < 6) ? ((k % 2 == 0) ? 2'b10 : 2'b01) : 2'b00);
            chk($sformatf("cont_rsp_%0d", k), ld_rsp_valid,
                (k >= 2 && k < 8) ? ((k % 2 == 0) ? 2'b10 : 2'b01) : 2'b00);
            if (k >= 2 && k < 8) begin
                if (k % 2 == 0)
                    chk($sformatf("cont_data1_%0d", k), ld_rsp_data[63:32], 32'h21);
                else
                    chk($sformatf("cont_data0_%0d", k), ld_rsp_data[31:0], 32'h20);
            end
        end

        // Backpressure on requester 1.
        nxt();
        ld_rsp_ready = 2'b01;
        ld_req_valid = 2'b10;
        smp();
        chk("bp_first_grant", ld_req_ready, 2'b10);
        nxt();
        ld_req_valid = 2'b00;
        for (int k = 0; k < 3; k++) begin
            nxt();
            ld_req_valid = 2'b11;
            smp();
            chk($sformatf("bp_ready_%0d", k), ld_req_ready, 2'b01);
            chk($sformatf("bp_hold_v_%0d", k), ld_rsp_valid[1], 1'b1);
            chk($sformatf("bp_hold_d_%0d", k), ld_rsp_data[63:32], 32'h21);
        end
        nxt();
        ld_rsp_ready = 2'b11;
        smp();
        chk("bp_release_grant", ld_req_ready, 2'b10);
        chk("bp_release_rsp", ld_rsp_valid, 2'b11);
        nxt();
        ld_req_valid = 2'b00;
        smp();
        chk("bp_drain_a", ld_rsp_valid, 2'b01);
        nxt();
        smp();
        chk("bp_drain_b", ld_rsp_valid, 2'b10);
        chk("bp_drain_data", ld_rsp_data[63:32], 32'h21);
        nxt();
        smp();
        chk("bp_drain_empty", ld_rsp_valid, 2'b00);

        // Parallel store (req 0) and load (req 1).
        nxt();
        st_valid = 2'b01;
        st_addr = {32'd0, 32'd7};
        st_data = {32'd0, 32'h1234};
        ld_req_valid = 2'b10;
        ld_req_addr = {32'd9, 32'd0};
        smp();
        chk("par_st_ready", st_ready, 2'b01);
        chk("par_ld_ready", ld_req_ready, 2'b10);
        chk("par_ce", {ce0, ce1, we1}, 3'b111);
        chk("par_address1", address1, 32'd7);
        chk("par_dout1", dout1, 32'h1234);
        chk("par_address0", address0, 32'd9);
        nxt();
        st_valid = 2'b00;
        ld_req_valid = 2'b00;
        smp();
        chk("par_idle_ce1", {ce1, we1}, 2'b00);
        chk("par_hold_addr1", address1, 32'd7);
        chk("par_hold_dout1", dout1, 32'h1234);
        nxt();
        smp();
        chk("par_rsp_valid", ld_rsp_valid, 2'b10);
        chk("par_rsp_data", ld_rsp_data[63:32], 32'h9999);
        nxt();
        ld_req_valid = 2'b01;
        ld_req_addr = {32'd0, 32'd7};
        smp();
        chk("readback_ready", ld_req_ready, 2'b01);
        nxt();
        ld_req_valid = 2'b00;
        nxt();
        smp();
        chk("readback_valid", ld_rsp_valid, 2'b01);
        chk("readback_data", ld_rsp_data[31:0], 32'h1234);

        // Same-address load and store in one cycle.
        nxt();
        st_valid = 2'b10;
        st_addr = {32'd3, 32'd0};
        st_data = {32'hBEEF, 32'd0};
        ld_req_valid = 2'b01;
        ld_req_addr = {32'd0, 32'd3};
        smp();
        chk("fwd_st_ready", st_ready, 2'b10);
        chk("fwd_ld_ready", ld_req_ready, 2'b01);
        nxt();
        st_valid = 2'b00;
        ld_req_valid = 2'b00;
        nxt();
        smp();
        chk("fwd_valid", ld_rsp_valid, 2'b01);
        chk("fwd_data", ld_rsp_data[31:0], {32'd0, fwd_exp});
        nxt();
        ld_req_valid = 2'b01;
        nxt();
        ld_req_valid = 2'b00;
        nxt();
        smp();
        chk("fwd_mem_valid", ld_rsp_valid, 2'b01);
        chk("fwd_mem_data", ld_rsp_data[31:0], 32'hBEEF);

        // Reset right after a load grant.
        nxt();
        ld_req_valid = 2'b10;
        ld_req_addr = {32'd21, 32'd20};
        smp();
        chk("rmid_grant", ld_req_ready, 2'b10);
        nxt();
        rst = 1'b0;
        ld_req_valid = 2'b00;
        smp();
        chk("rmid_valid_a", ld_rsp_valid, 2'b00);
        nxt();
        rst = 1'b1;
        smp();
        chk("rmid_valid_b", ld_rsp_valid, 2'b00);
        nxt();
        ld_req_valid = 2'b11;
        smp();
        chk("rmid_first_winner", ld_req_ready, 2'b01);
        chk("rmid_valid_c", ld_rsp_valid, 2'b00);
        nxt();
        ld_req_valid = 2'b00;
        nxt();
        smp();
        chk("rmid_rsp_valid", ld_rsp_valid, 2'b01);
        chk("rmid_rsp_data", ld_rsp_data[31:0], 32'h20);

        repeat (2) nxt();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
